// File: rtl/imm_decode_stage.sv
// Registered immediate extractor with a 2-entry elastic output buffer.
// Decodes format and sign-extends the immediate; carries a sideband tag.
module imm_decode_stage #(
    parameter int XLEN         = 32,
    parameter int TAG_W        = 32,
    parameter bit ENABLE_ZICSR = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [31:0]      instruction_word_i,
    input  logic [TAG_W-1:0] in_tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  ext_immediate_o,
    output logic [2:0]       imm_format_o,
    output logic             has_imm_o,
    output logic [TAG_W-1:0] out_tag_o
);

    typedef enum logic [2:0] {
        FMT_NONE = 3'd0,
        FMT_I    = 3'd1,
        FMT_S    = 3'd2,
        FMT_B    = 3'd3,
        FMT_U    = 3'd4,
        FMT_J    = 3'd5,
        FMT_Z    = 3'd6,
        FMT_RSVD = 3'd7
    } fmt_e;

    typedef struct packed {
        logic [XLEN-1:0]  imm;
        fmt_e             fmt;
        logic [TAG_W-1:0] tag;
    } entry_t;

    logic [31:0] inst;
    logic [6:0]  opcode;
    logic [31:0] imm32;
    fmt_e        dec_fmt;
    entry_t      dec;

    assign inst   = instruction_word_i;
    assign opcode = inst[6:0];

    always_comb begin
        dec_fmt = FMT_NONE;
        imm32   = '0;
        unique case (opcode)
            7'b0010011,
            7'b0000011,
            7'b1100111: begin
                dec_fmt = FMT_I;
                imm32   = {{20{inst[31]}}, inst[31:20]};
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                imm32   = {{19{inst[31]}}, inst[31], inst[7],
                           inst[30:25], inst[11:8], 1'b0};
            end
            7'b0110111,
            7'b0010111: begin
                dec_fmt = FMT_U;
                imm32   = {inst[31:12], 12'b0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                imm32   = {{11{inst[31]}}, inst[31], inst[19:12],
                           inst[20], inst[30:21], 1'b0};
            end
            7'b1110011: begin
                if (ENABLE_ZICSR && inst[14]) begin
                    dec_fmt = FMT_Z;
                    imm32   = {27'b0, inst[19:15]};
                end
            end
            default: begin
                dec_fmt = FMT_NONE;
                imm32   = '0;
            end
        endcase
    end

    // Z keeps bit 31 clear, so one sign-extension path serves all formats.
    always_comb begin
        dec.imm = XLEN'($signed(imm32));
        dec.fmt = dec_fmt;
        dec.tag = in_tag_i;
    end

    logic [1:0] count, count_n;
    entry_t     head, head_n;
    entry_t     tail, tail_n;
    logic       rdy_q;
    logic       push, pop;

    assign push = in_valid_i && rdy_q && !flush_i;
    assign pop  = (count != 2'd0) && out_ready_i;

    always_comb begin
        count_n = count;
        head_n  = head;
        tail_n  = tail;
        if (flush_i) begin
            count_n = 2'd0;
            head_n  = '0;
            tail_n  = '0;
        end else begin
            unique case (count)
                2'd0: begin
                    if (push) begin
                        head_n  = dec;
                        count_n = 2'd1;
                    end
                end
                2'd1: begin
                    if (push && pop) begin
                        head_n = dec;
                    end else if (push) begin
                        tail_n  = dec;
                        count_n = 2'd2;
                    end else if (pop) begin
                        head_n  = '0;
                        count_n = 2'd0;
                    end
                end
                2'd2: begin
                    // in_ready is low at count 2, so only a pop can occur
                    if (pop) begin
                        head_n  = tail;
                        tail_n  = '0;
                        count_n = 2'd1;
                    end
                end
                default: begin
                    count_n = 2'd0;
                    head_n  = '0;
                    tail_n  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            count <= 2'd0;
            head  <= '0;
            tail  <= '0;
            rdy_q <= 1'b0;
        end else begin
            count <= count_n;
            head  <= head_n;
            tail  <= tail_n;
            rdy_q <= (count_n < 2'd2) && !flush_i;
        end
    end

    assign in_ready_o      = rdy_q;
    assign out_valid_o     = (count != 2'd0);
    assign ext_immediate_o = head.imm;
    assign imm_format_o    = head.fmt;
    assign has_imm_o       = (head.fmt != FMT_NONE);
    assign out_tag_o       = head.tag;

endmodule
